// File: rtl/lsu_multiciclo.sv
// Load/store unit for the multicycle RISC-V datapath: lane alignment, strobes, load extension, fault reporting.
// Optional watchdog on the memory wait is enabled with `define LSU_TIMEOUT_EN.
module lsu_multiciclo #(
  parameter int XLEN           = 64,
  parameter int ADDR_W         = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_store,
  input  logic [2:0]          funct3,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [XLEN-1:0]     wdata,
  output logic                resp_valid,
  output logic [XLEN-1:0]     rdata,
  output logic [1:0]          fault,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [XLEN/8-1:0]   mem_wstrb,
  input  logic                mem_ack,
  input  logic [XLEN-1:0]     mem_rdata
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  typedef enum logic [1:0] {IDLE, MEM, RESP, ERR} state_t;
  state_t state, next_state;

  logic              store_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   load_q;
  logic [1:0]        cause_q;
  logic [OFFW-1:0]   off_in, off_q;
  logic [2:0]        size_mask, off_ext;
  logic              accept, illegal, misaligned, timeout;

  function automatic logic [NB-1:0] base_strb(input logic [1:0] size);
    logic [7:0] b;
    case (size)
      2'd0:    b = 8'h01;
      2'd1:    b = 8'h03;
      2'd2:    b = 8'h0F;
      default: b = 8'hFF;
    endcase
    return b[NB-1:0];
  endfunction

  // Shift the addressed lane down, keep its width, then sign- or zero-extend.
  function automatic logic [XLEN-1:0] ext_load(input logic [XLEN-1:0] word,
                                               input logic [2:0] f3,
                                               input logic [OFFW-1:0] off);
    logic [XLEN-1:0] shifted, mask;
    logic            sign;
    shifted = word >> {off, 3'b000};
    mask    = '0;
    case (f3[1:0])
      2'd0:    begin mask[7:0]  = '1; sign = shifted[7];      end
      2'd1:    begin mask[15:0] = '1; sign = shifted[15];     end
      2'd2:    begin mask[31:0] = '1; sign = shifted[31];     end
      default: begin mask       = '1; sign = shifted[XLEN-1]; end
    endcase
    if (!f3[2] && sign) return shifted | ~mask;
    return shifted & mask;
  endfunction

  assign accept = req_valid && (state == IDLE);
  assign off_in = addr[OFFW-1:0];
  assign off_q  = addr_q[OFFW-1:0];

  always_comb begin
    illegal = (funct3 == 3'b111) || (req_store && funct3[2]);
    if (XLEN == 32 && (funct3 == 3'b011 || funct3 == 3'b110)) illegal = 1'b1;
    size_mask  = 3'((4'd1 << funct3[1:0]) - 4'd1);
    off_ext    = 3'(off_in);
    misaligned = |(off_ext & size_mask);
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt;

  // Held at zero outside MEM so it starts cleared on every entry.
  always_ff @(posedge clock) begin
    if (reset)              cnt <= '0;
    else if (state != MEM)  cnt <= '0;
    else if (!mem_ack)      cnt <= cnt + 1'b1;
  end

  assign timeout = (state == MEM) && !mem_ack && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = (illegal || misaligned) ? ERR : MEM;
      MEM:  if (mem_ack) next_state = RESP;
            else if (timeout) next_state = ERR;
      RESP: next_state = IDLE;
      ERR:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request and result holding registers; outputs are gated by state so these need no reset.
  always_ff @(posedge clock) begin
    if (accept) begin
      store_q <= req_store;
      f3_q    <= funct3;
      addr_q  <= addr;
      wdata_q <= wdata;
      cause_q <= illegal ? 2'b10 : 2'b01;
    end else if (timeout) begin
      cause_q <= 2'b11;
    end
    if (state == MEM && mem_ack)
      load_q <= store_q ? '0 : ext_load(mem_rdata, f3_q, off_q);
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    rdata      = '0;
    fault      = 2'b00;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wstrb  = '0;
    case (state)
      IDLE: req_ready = 1'b1;
      MEM: begin
        mem_req   = 1'b1;
        mem_we    = store_q;
        mem_addr  = {addr_q[ADDR_W-1:OFFW], {OFFW{1'b0}}};
        mem_wdata = wdata_q << {off_q, 3'b000};
        mem_wstrb = store_q ? (base_strb(f3_q[1:0]) << off_q) : '0;
      end
      RESP: begin
        resp_valid = 1'b1;
        rdata      = load_q;
      end
      ERR: begin
        resp_valid = 1'b1;
        fault      = cause_q;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_lsu_multiciclo.sv
// Directed self-checking bench for lsu_multiciclo (64-bit instance plus a 32-bit instance).
module tb_lsu_multiciclo;
  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_store, req_ready, resp_valid, mem_req, mem_we, mem_ack;
  logic [2:0]  funct3;
  logic [63:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  fault;
  logic [7:0]  mem_wstrb;

  logic        q_valid, q_store, q_ready, q_resp_valid, q_mem_req, q_mem_we, q_mem_ack;
  logic [2:0]  q_funct3;
  logic [63:0] q_addr, q_mem_addr;
  logic [31:0] q_wdata, q_rdata, q_mem_wdata, q_mem_rdata;
  logic [1:0]  q_fault;
  logic [3:0]  q_mem_wstrb;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  lsu_multiciclo #(.XLEN(64), .ADDR_W(64), .TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .funct3(funct3), .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid), .rdata(rdata), .fault(fault), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  lsu_multiciclo #(.XLEN(32), .ADDR_W(64), .TIMEOUT_CYCLES(8)) dut32 (
    .clock(clock), .reset(reset), .req_valid(q_valid), .req_ready(q_ready),
    .req_store(q_store), .funct3(q_funct3), .addr(q_addr), .wdata(q_wdata),
    .resp_valid(q_resp_valid), .rdata(q_rdata), .fault(q_fault), .mem_req(q_mem_req),
    .mem_we(q_mem_we), .mem_addr(q_mem_addr), .mem_wdata(q_mem_wdata), .mem_wstrb(q_mem_wstrb),
    .mem_ack(q_mem_ack), .mem_rdata(q_mem_rdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present one request on the 64-bit unit; returns in the cycle after acceptance.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd);
    req_valid = 1'b1;
    req_store = st;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_store = 1'b0; funct3 = 3'b000; addr = '0; wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    q_valid = 1'b0; q_store = 1'b0; q_funct3 = 3'b000; q_addr = '0; q_wdata = '0;
    q_mem_ack = 1'b0; q_mem_rdata = '0;
    step(); step();
    reset = 1'b0;
    step();
    check("rst_ready",  64'(req_ready), 64'd1);
    check("rst_resp",   64'(resp_valid), 64'd0);
    check("rst_memreq", 64'(mem_req), 64'd0);
    check("rst_rdata",  rdata, 64'd0);
    check("rst_fault",  64'(fault), 64'd0);

    // LB 0x1003, ack on first MEM cycle
    issue(1'b0, 3'b000, 64'h1003, 64'd0);
    check("lb_memreq", 64'(mem_req), 64'd1);
    check("lb_addr",   mem_addr, 64'h1000);
    check("lb_strb",   64'(mem_wstrb), 64'h00);
    check("lb_we",     64'(mem_we), 64'd0);
    check("lb_ready",  64'(req_ready), 64'd0);
    mem_ack = 1'b1; mem_rdata = 64'h1122334485667788;
    step();
    mem_ack = 1'b0;
    check("lb_resp",   64'(resp_valid), 64'd1);
    check("lb_rdata",  rdata, 64'hFFFFFFFFFFFFFF85);
    check("lb_fault",  64'(fault), 64'd0);
    check("lb_rdy_resp", 64'(req_ready), 64'd0);
    step();
    check("lb_resp_end", 64'(resp_valid), 64'd0);
    check("lb_rdata_end", rdata, 64'd0);
    check("lb_ready_end", 64'(req_ready), 64'd1);

    // LBU same access, issued right after the response cycle
    issue(1'b0, 3'b100, 64'h1003, 64'd0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("lbu_rdata", rdata, 64'h85);
    step();

    // LW 0x1004 sign-extended upper word
    issue(1'b0, 3'b010, 64'h1004, 64'd0);
    mem_ack = 1'b1; mem_rdata = 64'h8765432100000000;
    step();
    mem_ack = 1'b0;
    check("lw_rdata", rdata, 64'hFFFFFFFF87654321);
    step();

    // SH 0x1006
    issue(1'b1, 3'b001, 64'h1006, 64'hABCD);
    check("sh_we",    64'(mem_we), 64'd1);
    check("sh_strb",  64'(mem_wstrb), 64'hC0);
    check("sh_wdata", mem_wdata, 64'hABCD000000000000);
    check("sh_addr",  mem_addr, 64'h1000);
    mem_ack = 1'b1; mem_rdata = 64'hFFFFFFFFFFFFFFFF;
    step();
    mem_ack = 1'b0;
    check("sh_resp",  64'(resp_valid), 64'd1);
    check("sh_rdata", rdata, 64'd0);
    step();

    // LW 0x1002: misaligned, response in cycle 1
    issue(1'b0, 3'b010, 64'h1002, 64'd0);
    check("mis_resp",   64'(resp_valid), 64'd1);
    check("mis_fault",  64'(fault), 64'd1);
    check("mis_memreq", 64'(mem_req), 64'd0);
    check("mis_rdata",  rdata, 64'd0);
    step();
    check("mis_after", 64'(resp_valid), 64'd0);

    // funct3 111 on a misaligned address: illegal wins
    issue(1'b0, 3'b111, 64'h1001, 64'd0);
    check("ill_prio", 64'(fault), 64'd2);
    check("ill_memreq", 64'(mem_req), 64'd0);
    step();

    // store with funct3[2]=1 is illegal
    issue(1'b1, 3'b100, 64'h1000, 64'd0);
    check("ill_store", 64'(fault), 64'd2);
    step();

    // LD 0x2000 with ack after 5 MEM cycles
    issue(1'b0, 3'b011, 64'h2000, 64'd0);
    for (int i = 0; i < 5; i++) begin
      check("ld_wait_req",   64'(mem_req), 64'd1);
      check("ld_wait_addr",  mem_addr, 64'h2000);
      check("ld_wait_ready", 64'(req_ready), 64'd0);
      check("ld_wait_resp",  64'(resp_valid), 64'd0);
      if (i == 4) begin
        mem_ack = 1'b1; mem_rdata = 64'h8000000000000001;
      end
      step();
    end
    mem_ack = 1'b0;
    check("ld_resp",  64'(resp_valid), 64'd1);
    check("ld_rdata", rdata, 64'h8000000000000001);
    check("ld_memreq_off", 64'(mem_req), 64'd0);
    step();
    check("ld_one_pulse", 64'(resp_valid), 64'd0);

    // ack while idle is ignored
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("idle_ack_resp",  64'(resp_valid), 64'd0);
    check("idle_ack_ready", 64'(req_ready), 64'd1);

    // reset during third MEM cycle, then a normal LBU
    issue(1'b0, 3'b011, 64'h3000, 64'd0);
    step(); step();
    check("rst_mid_memreq_before", 64'(mem_req), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid_memreq", 64'(mem_req), 64'd0);
    check("rst_mid_ready",  64'(req_ready), 64'd1);
    check("rst_mid_resp",   64'(resp_valid), 64'd0);
    step();
    check("rst_mid_noresp", 64'(resp_valid), 64'd0);
    issue(1'b0, 3'b100, 64'h0, 64'd0);
    mem_ack = 1'b1; mem_rdata = 64'h00000000000000F0;
    step();
    mem_ack = 1'b0;
    check("post_rst_resp",  64'(resp_valid), 64'd1);
    check("post_rst_rdata", rdata, 64'hF0);
    step();

    // Long wait without ack
    issue(1'b0, 3'b011, 64'h4000, 64'd0);
`ifdef LSU_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      check("to_memreq", 64'(mem_req), 64'd1);
      step();
    end
    check("to_resp",   64'(resp_valid), 64'd1);
    check("to_fault",  64'(fault), 64'd3);
    check("to_rdata",  rdata, 64'd0);
    check("to_memreq_off", 64'(mem_req), 64'd0);
    step();
`else
    for (int i = 0; i < 20; i++) begin
      check("nto_memreq", 64'(mem_req), 64'd1);
      check("nto_resp",   64'(resp_valid), 64'd0);
      step();
    end
    mem_ack = 1'b1; mem_rdata = 64'h0123456789ABCDEF;
    step();
    mem_ack = 1'b0;
    check("nto_fault", 64'(fault), 64'd0);
    check("nto_rdata", rdata, 64'h0123456789ABCDEF);
    step();
`endif

    // 32-bit instance: LD illegal, LH sign extension, SB strobes
    q_valid = 1'b1; q_store = 1'b0; q_funct3 = 3'b011; q_addr = 64'h0;
    step();
    q_valid = 1'b0;
    check("x32_ld_resp",   64'(q_resp_valid), 64'd1);
    check("x32_ld_fault",  64'(q_fault), 64'd2);
    check("x32_ld_memreq", 64'(q_mem_req), 64'd0);
    step();
    q_valid = 1'b1; q_store = 1'b0; q_funct3 = 3'b001; q_addr = 64'h1002;
    step();
    q_valid = 1'b0;
    check("x32_lh_addr", q_mem_addr, 64'h1000);
    q_mem_ack = 1'b1; q_mem_rdata = 32'h80010000;
    step();
    q_mem_ack = 1'b0;
    check("x32_lh_rdata", 64'(q_rdata), 64'hFFFF8001);
    step();
    q_valid = 1'b1; q_store = 1'b1; q_funct3 = 3'b000; q_addr = 64'h1001; q_wdata = 32'h5A;
    step();
    q_valid = 1'b0;
    check("x32_sb_we",    64'(q_mem_we), 64'd1);
    check("x32_sb_strb",  64'(q_mem_wstrb), 64'h2);
    check("x32_sb_wdata", 64'(q_mem_wdata), 64'h5A00);
    q_mem_ack = 1'b1;
    step();
    q_mem_ack = 1'b0;
    check("x32_sb_rdata", 64'(q_rdata), 64'd0);
    check("x32_sb_fault", 64'(q_fault), 64'd0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
